// File: rtl/udma_i2c_cmd_arbiter.sv
// udma_i2c_cmd_arbiter: round-robin sharing of the uDMA I2C command stream with START..STOP locking.
// Define I2C_ARB_TIMEOUT_EN to release a lock whose owner stays idle for TIMEOUT_CYC cycles.
module udma_i2c_cmd_arbiter #(
  parameter int N_REQ = 2,
  parameter logic [3:0] CMD_START = 4'h0,
  parameter logic [3:0] CMD_STOP = 4'h2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int IDW = $clog2(N_REQ)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [N_REQ*32-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [31:0]        cmd_data_o,
  output logic               cmd_valid_o,
  input  logic               cmd_ready_i,
  output logic [IDW-1:0]     owner_o,
  output logic               locked_o,
  input  logic               flush_i,
  output logic               timeout_o,
  input  logic               timeout_clr_i
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;
  logic [IDW-1:0] rr_ptr, grant, idx, sel, nxt;
  logic any_valid, slot_free, accept, to_hit;
  logic [31:0] sel_data;
  always_comb begin
    grant = rr_ptr;
    any_valid = 1'b0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = IDW'((int'(rr_ptr) + i) % N_REQ);
      if (req_valid_i[idx]) begin
        grant = idx;
        any_valid = 1'b1;
      end
    end
  end
  assign slot_free = !cmd_valid_o || cmd_ready_i;
  assign sel = (state == LOCKED) ? owner_o : grant;
  assign nxt = (int'(sel) + 1 == N_REQ) ? '0 : IDW'(int'(sel) + 1);
  assign sel_data = req_data_i[{sel, 5'd0} +: 32];
  assign locked_o = (state == LOCKED);
  // Gated by reset and flush so nothing is ever handshaken in those cycles.
  always_comb begin
    req_ready_o = '0;
    if (rstn_i && slot_free && !flush_i && (state == LOCKED || any_valid)) req_ready_o[sel] = 1'b1;
  end
  assign accept = |(req_valid_i & req_ready_o);
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner_o <= '0;
      cmd_data_o <= '0;
      cmd_valid_o <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
      rr_ptr <= '0;
      cmd_valid_o <= 1'b0;
    end else begin
      if (accept) begin
        cmd_valid_o <= 1'b1;
        cmd_data_o <= sel_data;
      end else if (cmd_ready_i) cmd_valid_o <= 1'b0;
      if (to_hit) state <= IDLE;
      else if (accept && state == IDLE) begin
        owner_o <= grant;
        rr_ptr <= nxt;
        if (sel_data[31:28] == CMD_START) state <= LOCKED;
      end else if (accept && sel_data[31:28] == CMD_STOP) state <= IDLE;
    end
  end
`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] idle_cnt;
  assign to_hit = !flush_i && state == LOCKED && !req_valid_i[owner_o] && idle_cnt >= 16'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      idle_cnt <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (flush_i || state == IDLE || accept || to_hit) idle_cnt <= '0;
      else if (!req_valid_i[owner_o] && idle_cnt != 16'hFFFF) idle_cnt <= idle_cnt + 16'd1;
      if (to_hit) timeout_o <= 1'b1;
      else if (timeout_clr_i) timeout_o <= 1'b0;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = timeout_clr_i & (TIMEOUT_CYC > 0);
  assign to_hit = 1'b0;
  assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_udma_i2c_cmd_arbiter.sv
// tb_udma_i2c_cmd_arbiter: directed and randomized checks against a transaction-level arbiter model.
module tb_udma_i2c_cmd_arbiter;
  localparam int N = 2;
  localparam int TO = 8;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b0;
  logic [N*32-1:0] req_data = '0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [31:0] cmd_data;
  logic cmd_valid, cmd_ready = 1'b0, locked, flush = 1'b0, timeout, clr = 1'b0;
  logic [$clog2(N)-1:0] owner;
  int tests = 0, fails = 0, cyc = 0, vprob = 100;
  logic [31:0] q [N][$];
  logic [31:0] out_log [$];
  int out_cyc [$];
  bit m_valid, m_locked, m_to;
  logic [31:0] m_data;
  int m_owner, m_rr, m_idle;

  always #5 clk = ~clk;

  udma_i2c_cmd_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rstn_i(rstn), .req_data_i(req_data), .req_valid_i(req_valid),
    .req_ready_o(req_ready), .cmd_data_o(cmd_data), .cmd_valid_o(cmd_valid),
    .cmd_ready_i(cmd_ready), .owner_o(owner), .locked_o(locked), .flush_i(flush),
    .timeout_o(timeout), .timeout_clr_i(clr)
  );

  function automatic bit vld(int k);
    return ((req_valid >> k) & 1) != 0;
  endfunction

  // Which requester the spec says gets the beat at the coming edge (-1 for none).
  function automatic int pick();
    if (flush || !rstn || (m_valid && !cmd_ready)) return -1;
    if (m_locked) return vld(m_owner) ? m_owner : -1;
    for (int i = 0; i < N; i++) if (vld((m_rr + i) % N)) return (m_rr + i) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_locked = 0; m_to = 0; m_data = '0; m_owner = 0; m_rr = 0; m_idle = 0;
  endtask

  task automatic clear_q();
    for (int j = 0; j < N; j++) q[j].delete();
    out_log.delete();
    out_cyc.delete();
  endtask

  task automatic cycle();
    int k;
    bit hit;
    logic [N-1:0] acc, exp_acc;
    logic [31:0] w;
    for (int j = 0; j < N; j++) begin
      req_valid[j] = q[j].size() > 0 && $urandom_range(0, 99) < vprob;
      req_data[j*32 +: 32] = q[j].size() > 0 ? q[j][0] : $urandom;
    end
    #1;
    k = pick();
    exp_acc = '0;
    if (k >= 0) exp_acc[k] = 1'b1;
    acc = req_valid & req_ready;
    tests++;
    if (acc !== exp_acc) begin
      fails++;
      $display("FAIL accept cyc %0d: got %b want %b", cyc, acc, exp_acc);
    end
    if (cmd_valid && cmd_ready) begin
      out_log.push_back(cmd_data);
      out_cyc.push_back(cyc);
    end
    for (int j = 0; j < N; j++) if (acc[j]) void'(q[j].pop_front());
    w = k >= 0 ? req_data[k*32 +: 32] : '0;
    @(posedge clk);
    cyc++;
    hit = 0;
    if (flush) begin
      m_valid = 0; m_locked = 0; m_rr = 0; m_idle = 0;
    end else begin
      if (TO_EN && m_locked && !vld(m_owner)) begin
        m_idle++;
        if (m_idle >= TO) begin hit = 1; m_locked = 0; m_idle = 0; end
      end
      if (k >= 0) begin
        m_valid = 1; m_data = w; m_idle = 0;
        if (!m_locked) begin
          m_owner = k; m_rr = (k + 1) % N; m_locked = (w[31:28] == 4'h0);
        end else if (w[31:28] == 4'h2) m_locked = 0;
      end else if (cmd_ready) m_valid = 0;
    end
    if (hit) m_to = 1;
    else if (clr) m_to = 0;
    @(negedge clk);
    tests++;
    if ({cmd_valid, locked, timeout} !== {m_valid, m_locked, m_to} || int'(owner) != m_owner ||
        (m_valid && cmd_data !== m_data)) begin
      fails++;
      $display("FAIL state cyc %0d: got v%b l%b t%b o%0d d%h want v%b l%b t%b o%0d d%h", cyc,
               cmd_valid, locked, timeout, owner, cmd_data, m_valid, m_locked, m_to, m_owner, m_data);
    end
  endtask

  task automatic check_log(input logic [31:0] exp [], input string name);
    tests++;
    if (out_log.size() != exp.size()) begin
      fails++;
      $display("FAIL %s count: got %0d want %0d", name, out_log.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < out_log.size(); i++) begin
      tests++;
      if (out_log[i] !== exp[i] || out_cyc[i] != out_cyc[0] + i) begin
        fails++;
        $display("FAIL %s beat %0d: got %h@%0d want %h@%0d", name, i, out_log[i], out_cyc[i], exp[i], out_cyc[0] + i);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 0;
    model_reset();
    req_valid = '1;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({cmd_valid, locked, timeout, owner, cmd_data, req_ready} !== '0) begin
      fails++;
      $display("FAIL reset: got v%b l%b t%b o%0d d%h r%b want all zero", cmd_valid, locked, timeout, owner, cmd_data, req_ready);
    end
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp [];
    clear_q();
    cmd_ready = 1;
    for (int i = 0; i < 3; i++) begin
      q[0].push_back(32'h1000_0000);
      q[1].push_back(32'h1000_0001);
    end
    repeat (8) cycle();
    exp = new[6];
    for (int i = 0; i < 6; i++) exp[i] = 32'h1000_0000 | 32'(i % 2);
    check_log(exp, "round_robin");
  endtask

  task automatic test_lock();
    clear_q();
    cmd_ready = 1;
    flush = 1; cycle(); flush = 0;
    out_log.delete(); out_cyc.delete();
    q[0].push_back(32'h0000_0000);
    q[0].push_back(32'h8000_00AA);
    q[0].push_back(32'h2000_0000);
    q[1].push_back(32'h1000_0001);
    repeat (6) cycle();
    check_log('{32'h0000_0000, 32'h8000_00AA, 32'h2000_0000, 32'h1000_0001}, "lock");
  endtask

  task automatic test_backpressure();
    clear_q();
    cmd_ready = 0;
    q[0].push_back(32'h1000_0000);
    q[0].push_back(32'h1000_0002);
    cycle();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (cmd_data !== 32'h1000_0000 || req_ready !== '0) begin
        fails++;
        $display("FAIL backpressure hold %0d: got d%h r%b want d10000000 r0", i, cmd_data, req_ready);
      end
      cycle();
    end
    cmd_ready = 1;
    cycle();
    tests++;
    if (cmd_valid !== 1'b1 || cmd_data !== 32'h1000_0002) begin
      fails++;
      $display("FAIL backpressure release: got v%b d%h want v1 d10000002", cmd_valid, cmd_data);
    end
    cycle();
  endtask

  task automatic test_flush();
    clear_q();
    cmd_ready = 0;
    flush = 1; cycle(); flush = 0;
    q[0].push_back(32'h0000_0000);
    cycle();
    tests++;
    if (locked !== 1'b1 || cmd_valid !== 1'b1) begin
      fails++;
      $display("FAIL flush setup: got l%b v%b want l1 v1", locked, cmd_valid);
    end
    q[0].push_back(32'h1000_0000);
    q[1].push_back(32'h1000_0001);
    flush = 1; cycle(); flush = 0;
    tests++;
    if (cmd_valid !== 1'b0 || locked !== 1'b0 || owner !== '0) begin
      fails++;
      $display("FAIL flush: got v%b l%b o%0d want v0 l0 o0", cmd_valid, locked, owner);
    end
    cmd_ready = 1;
    cycle();
    tests++;
    if (cmd_valid !== 1'b1 || cmd_data !== 32'h1000_0000) begin
      fails++;
      $display("FAIL flush rr_ptr: got v%b d%h want v1 d10000000", cmd_valid, cmd_data);
    end
    repeat (2) cycle();
  endtask

  task automatic test_timeout();
    bit exp_hit;
    clear_q();
    cmd_ready = 1;
    flush = 1; cycle(); flush = 0;
    q[0].push_back(32'h0000_0000);
    cycle();
    for (int i = 1; i <= TO; i++) begin
      cycle();
      exp_hit = TO_EN && i == TO;
      tests++;
      if (locked !== !exp_hit || timeout !== exp_hit) begin
        fails++;
        $display("FAIL timeout idle %0d: got l%b t%b want l%b t%b", i, locked, timeout, !exp_hit, exp_hit);
      end
    end
    clr = 1; cycle(); clr = 0;
    tests++;
    if (timeout !== 1'b0) begin
      fails++;
      $display("FAIL timeout clear: got %b want 0", timeout);
    end
    flush = 1; cycle(); flush = 0;
  endtask

  task automatic test_reset_mid();
    clear_q();
    cmd_ready = 0;
    flush = 1; cycle(); flush = 0;
    q[1].push_back(32'h0000_0000);
    q[1].push_back(32'h1000_0001);
    cycle();
    tests++;
    if (locked !== 1'b1 || owner !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid setup: got l%b o%0d want l1 o1", locked, owner);
    end
    #2 rstn = 0;
    #1;
    tests++;
    if ({cmd_valid, locked, timeout, owner, cmd_data, req_ready} !== '0) begin
      fails++;
      $display("FAIL reset_mid: got v%b l%b t%b o%0d d%h r%b want all zero", cmd_valid, locked, timeout, owner, cmd_data, req_ready);
    end
    model_reset();
    @(negedge clk);
    rstn = 1;
    clear_q();
  endtask

  task automatic test_random();
    logic [3:0] op;
    vprob = 75;
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < N; j++)
        while (q[j].size() < 2) begin
          case ($urandom_range(0, 3))
            0: op = 4'h0;
            1: op = 4'h2;
            default: op = 4'($urandom_range(0, 15));
          endcase
          q[j].push_back({op, 4'(j), 24'($urandom)});
        end
      cmd_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 39) == 0;
      cycle();
    end
    flush = 0;
    vprob = 100;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_flush();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/udma_i2c_cmd_arbiter.md
# udma_i2c_cmd_arbiter

- Shares the single uDMA I2C command stream between `N_REQ` command requesters, for example several cores or a core plus an autonomous sequencer.
- Output feeds the I2C command path, i.e. the `udma_cmd_*` stream that the register interface snoops.
- Arbitration is round-robin per beat when idle.
- A requester that issues a START command locks the stream until it issues a STOP, so I2C transactions are never interleaved on the bus.

## Interface

**Parameters**

- `N_REQ`, 2: number of requesters (2..8).
- `CMD_START`, 4'h0: opcode in bits [31:28] that opens a locked transaction.
- `CMD_STOP`, 4'h2: opcode in bits [31:28] that closes a locked transaction.
- `TIMEOUT_CYC`, 1024: owner idle limit in cycles (used only with `I2C_ARB_TIMEOUT_EN`).
- `IDW`, $clog2(N_REQ): owner index width.

**Ports**

- `clk_i` in 1: clock.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `req_data_i` in N_REQ*32: command words; requester k occupies [32k+31:32k].
- `req_valid_i` in N_REQ: per-requester valid.
- `req_ready_o` out N_REQ: per-requester ready; at most one bit high per cycle.
- `cmd_data_o` out 32: granted command word.
- `cmd_valid_o` out 1: output valid.
- `cmd_ready_i` in 1: downstream ready.
- `owner_o` out IDW: index of the requester holding the lock, or of the last granted requester.
- `locked_o` out 1: high while a transaction is locked.
- `flush_i` in 1: synchronous abort, driven from cfg_do_rst.
- `timeout_o` out 1: sticky timeout flag.
- `timeout_clr_i` in 1: clears `timeout_o`.

## Operation

**Output register**

- One-entry output register holds `cmd_data_o`/`cmd_valid_o`.
- A slot is free when `!cmd_valid_o || cmd_ready_i`.
- `req_ready_o` bits may be high only while the slot is free.
- A beat is accepted on `req_valid_i[k] & req_ready_o[k]`.

**FSM states: IDLE, LOCKED**

- IDLE, candidate selection: the first valid requester searching from `rr_ptr` upward, with wrap.
- IDLE, on acceptance:
  - `owner_o` ← k.
  - `rr_ptr` ← (k+1) mod N_REQ.
  - If opcode == `CMD_START`, go to LOCKED.
  - Any other opcode is a single-beat grant; stay in IDLE.
- LOCKED:
  - Only `req_ready_o[owner]` may be asserted; all other requesters are stalled.
  - Accepting an owner beat with opcode `CMD_STOP` returns to IDLE after that beat.
  - A nested `CMD_START` from the owner is forwarded and keeps the lock (repeated start).
- `locked_o` = (state == LOCKED).

**flush_i**

- Clears `cmd_valid_o`, discarding the pending word.
- Forces IDLE and sets `rr_ptr` ← 0.
- No beat is accepted in the flush cycle.
- Leaves `timeout_o` and `owner_o` unchanged.

**Reset values**

- `cmd_data_o` = 0, `cmd_valid_o` = 0, `req_ready_o` = 0, `owner_o` = 0, `locked_o` = 0, `timeout_o` = 0.
- State = IDLE, `rr_ptr` = 0.

## Timing

- Latency: accepted beat appears on `cmd_data_o` the next cycle.
- Throughput: one beat per cycle when `cmd_ready_i` stays high.
- `cmd_valid_o`/`cmd_data_o` are held stable until `cmd_ready_i`; data never changes while valid and not ready.
- `req_ready_o` is combinational from `req_valid_i`, state, `rr_ptr`, `cmd_valid_o` and `cmd_ready_i`. It never depends on `req_data_i`.
- The STOP beat releases the lock at the clock edge that accepts it. A new winner can be accepted in the very next cycle.
- Same-cycle events:
  - `flush_i` wins over acceptance and over timeout.
  - `timeout_clr_i` and a timeout event in the same cycle: set wins.
  - All requesters valid: pure rotation k, k+1, …, no requester is starved.

## Configuration

- Macro: `I2C_ARB_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter increments each LOCKED cycle with `!req_valid_i[owner]`.
  - It clears on any owner beat accepted and on entering LOCKED.
  - When it reaches `TIMEOUT_CYC` the FSM forces IDLE and `timeout_o` is set (sticky).
  - A word already in the output register is kept.
  - The counter saturates; it never wraps.
- Undefined:
  - No counter, and the lock is held indefinitely.
  - `timeout_o` is tied to 0 and `timeout_clr_i` is ignored.
  - `TIMEOUT_CYC` is unused.

## Test plan

1. Round-robin:
   - Stimulus: N_REQ=2, both requesters stream non-START words 0x1000_000k, `cmd_ready_i`=1.
   - Required: output alternates req0, req1, req0 …; one beat per cycle.
2. Lock:
   - Stimulus: req0 sends 0x0000_0000 (START), 0x8000_00AA, 0x2000_0000 (STOP), while req1 is valid throughout.
   - Required: the three req0 words are contiguous on the output; the req1 beat follows the cycle after the STOP is accepted.
3. Backpressure:
   - Stimulus: `cmd_ready_i`=0 for 5 cycles with one beat pending.
   - Required: `cmd_data_o` stable, `req_ready_o`=0; on release the next beat appears one cycle later.
4. Flush:
   - Stimulus: `flush_i` pulse while LOCKED with a valid output word.
   - Required: next cycle `cmd_valid_o`=0, `locked_o`=0, `rr_ptr`=0.
5. Timeout (`I2C_ARB_TIMEOUT_EN`, TIMEOUT_CYC=8):
   - Stimulus: req0 sends START then idles.
   - Required: after 8 idle cycles `locked_o`=0 and `timeout_o`=1; `timeout_clr_i` clears it.
   - Without the macro: `locked_o` stays 1.
6. Reset mid-transaction:
   - Stimulus: assert `rstn_i` low while LOCKED with a pending word.
   - Required: all outputs read their reset values immediately, without waiting for a clock edge.
